// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module  : des_pkg
// Brief   : Shared DES widths, IP/FP tables, permutation helpers, serializer state.
// Rev     : 1.0
// ============================================================================
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_HALF_W  = 32;

    // Entries are 1-based source positions, big-endian (position 1 = MSB).
    localparam logic [0:63][6:0] FP_TABLE = {
        7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    localparam logic [0:63][6:0] IP_TABLE = {
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int beats_of(input int out_w);
        return DES_BLOCK_W / out_w;
    endfunction

    // Vectors are [63:0] here, so big-endian position p lives at bit 64-p.
    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y = {y[62:0], x[6'(DES_BLOCK_W - int'(FP_TABLE[i[5:0]]))]};
        end
        return y;
    endfunction

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y = {y[62:0], x[6'(DES_BLOCK_W - int'(IP_TABLE[i[5:0]]))]};
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/final_permutation.sv
`default_nettype none
// ============================================================================
// Module  : final_permutation
// Brief   : Combinational DES IP^-1 on a big-endian [0:63] block.
// Rev     : 1.0
// ============================================================================
module final_permutation
    import des_pkg::*;
(
    input  logic [0:DES_BLOCK_W-1] i_data,
    output logic [0:DES_BLOCK_W-1] o_data
);

    for (genvar i = 0; i < DES_BLOCK_W; i++) begin : g_bit
        localparam int c_src = int'(FP_TABLE[i]) - 1;
        assign o_data[i] = i_data[c_src];
    end

endmodule
`default_nettype wire

// File: rtl/des_output_stage.sv
`default_nettype none
// ============================================================================
// Module  : des_output_stage
// Brief   : Swap L16/R16, apply IP^-1, buffer 2 blocks, stream MSB-first beats.
// Rev     : 1.0
// ============================================================================
module des_output_stage
    import des_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DES_HALF_W-1:0] in_left,
    input  logic [DES_HALF_W-1:0] in_right,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last,
    output logic [15:0]           blk_count
);

    localparam int BEATS    = beats_of(OUT_W);
    localparam int c_beat_w = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BEATS - 1);

    if (DEPTH != 2) begin : g_depth_check
        $error("des_output_stage: DEPTH must be 2");
    end
    if ((OUT_W < 1) || (OUT_W > DES_BLOCK_W) || ((DES_BLOCK_W % OUT_W) != 0)) begin : g_out_w_check
        $error("des_output_stage: OUT_W must divide 64");
    end

    logic [DES_BLOCK_W-1:0] w_pre;
    logic [DES_BLOCK_W-1:0] w_blk;
    logic [DES_BLOCK_W-1:0] w_next_head;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_beat;
    logic                   w_more;

    logic [DES_BLOCK_W-1:0] r_mem [0:1];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    ser_state_t             r_state;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [DES_BLOCK_W-1:0] r_shift;
    logic [c_beat_w-1:0]    r_beat;
    logic [15:0]            r_blk_count;

    assign w_pre = {in_right, in_left};

    final_permutation u_final_permutation (
        .i_data (w_pre),
        .o_data (w_blk)
    );

    assign in_ready    = !rst && (r_count != 2'd2);
    assign w_push      = in_valid && in_ready;
    assign w_last_beat = (r_beat == c_last_beat);
    assign w_pop       = (r_state == SEND) && out_ready && w_last_beat;

    // A block arriving on the same edge as the last beat is forwarded so the
    // serializer can continue without a bubble.
    assign w_more      = (r_count == 2'd2) || w_push;
    assign w_next_head = (r_count == 2'd2) ? r_mem[~r_rd_ptr] : w_blk;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_blk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The current beat is always the top OUT_W bits of r_shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_shift     <= '0;
            r_beat      <= '0;
            r_blk_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != 2'd0) begin
                        r_state     <= SEND;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (c_last_beat == '0);
                        r_shift     <= r_mem[r_rd_ptr];
                        r_beat      <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (w_last_beat) begin
                            r_blk_count <= r_blk_count + 16'd1;
                            r_beat      <= '0;
                            if (w_more) begin
                                r_out_last <= (c_last_beat == '0);
                                r_shift    <= w_next_head;
                            end else begin
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                            end
                        end else begin
                            r_beat     <= r_beat + 1'b1;
                            r_out_last <= ((r_beat + 1'b1) == c_last_beat);
                            r_shift    <= r_shift << OUT_W;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_shift[DES_BLOCK_W-1 -: OUT_W];
    assign blk_count = r_blk_count;

endmodule
`default_nettype wire
